// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared widths, FSM encoding and buffer entry type for the fetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int INSTR_W     = 32;
  localparam int ADDR_W      = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : small synchronous FIFO with flush and occupancy count
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  assign do_pop  = pop_i && valid_o;
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst_i)
    !(push_i && !do_pop && !flush_i && (count_q == CNT_W'(DEPTH))));

endmodule

`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
// ============================================================================
// instr_fetch_ctrl : PC owner, fetch issue, response capture and fault FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BOOT_ADDR  = 32'd16,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_instruction,
  input  logic               imem_valid,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic [ADDR_W-1:0]  fetch_pc,
  input  logic               fetch_ready,
  output logic               fault,
  output logic [ADDR_W-1:0]  fault_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  count;
  logic [OCC_W-1:0]  occ;
  logic              pop, push, live_rsp;
  fetch_entry_t      push_entry, head_entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= BOOT_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fault_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  always_comb begin
    pop      = fetch_valid && fetch_ready;
    occ      = {1'b0, count} + OCC_W'(inflight_q) - OCC_W'(pop);
    imem_req = !reset && (state_q == ST_RUN) && !halt && !redirect_valid && (occ < DEPTH_C);
    // A response is only live in RUN; a redirect in the same cycle kills it
    live_rsp = inflight_q && (state_q == ST_RUN) && !redirect_valid;
    push     = live_rsp && imem_valid;

    state_d       = state_q;
    pc_d          = pc_q;
    fault_pc_d    = fault_pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = inflight_pc_q;

    if (imem_req) begin
      inflight_pc_d = pc_q;
      pc_d          = pc_q + ADDR_W'(INSTR_BYTES);
    end

    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d    = ST_FAULT;
        fault_pc_d = redirect_pc;
      end else begin
        state_d = ST_RUN;
      end
    end else if (live_rsp && !imem_valid) begin
      state_d    = ST_FAULT;
      fault_pc_d = inflight_pc_q;
    end
  end

  assign push_entry = '{pc: inflight_pc_q, instr: imem_instruction};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_i   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop && !redirect_valid),
    .data_i  (push_entry),
    .data_o  (head_entry),
    .valid_o (fetch_valid),
    .count_o (count)
  );

  assign imem_addr   = pc_q;
  assign fetch_instr = head_entry.instr;
  assign fetch_pc    = head_entry.pc;
  assign fault       = (state_q == ST_FAULT);
  assign fault_pc    = fault_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
// ============================================================================
// tb_instr_fetch_ctrl : directed + randomized bench with an in-order delivery model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_instruction;
  logic        imem_valid;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        fault;
  logic [31:0] fault_pc;

  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  logic [31:0] exp_pc = 32'd16;
  logic [31:0] mem_words [16];

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .BOOT_ADDR  (32'd16),
    .FIFO_DEPTH (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_addr        (imem_addr),
    .imem_req         (imem_req),
    .imem_instruction (imem_instruction),
    .imem_valid       (imem_valid),
    .halt             (halt),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .fetch_valid      (fetch_valid),
    .fetch_instr      (fetch_instr),
    .fetch_pc         (fetch_pc),
    .fetch_ready      (fetch_ready),
    .fault            (fault),
    .fault_pc         (fault_pc)
  );

  function automatic logic in_range(input logic [31:0] a);
    return (a >= 32'd16) && (a < 32'd64) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [3:0] widx(input logic [31:0] a);
    logic [31:0] t;
    t = (a - 32'd16) >> 2;
    return t[3:0];
  endfunction

  // Instruction memory: valid range 16..63, one-cycle synchronous read
  always @(posedge clk) begin
    if (imem_req) begin
      if (in_range(imem_addr)) begin
        imem_instruction <= mem_words[widx(imem_addr)];
        imem_valid       <= 1'b1;
      end else begin
        imem_instruction <= $urandom;
        imem_valid       <= 1'b0;
      end
    end else begin
      imem_instruction <= $urandom;
      imem_valid       <= 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle: scores any handshake on this cycle, then advances one clock
  task automatic step();
    if (reset) begin
      exp_pc = 32'd16;
    end else if (redirect_valid) begin
      exp_pc = redirect_pc;
    end else if (fetch_valid && fetch_ready) begin
      chk("dlv_pc", fetch_pc, exp_pc);
      chk("dlv_in_range", {31'd0, in_range(fetch_pc)}, 32'd1);
      if (in_range(exp_pc)) chk("dlv_instr", fetch_instr, mem_words[widx(exp_pc)]);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      step();
    end
  endtask

  initial begin
    int dlv_before;
    bit seen;
    for (int i = 0; i < 16; i++) mem_words[i] = $urandom;
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; fetch_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset and streaming at one instruction per cycle
    for (int i = 0; i < 2; i++) begin
      #1; chk("req_in_reset", {31'd0, imem_req}, 32'd0); step();
    end
    reset = 1'b0;
    #1;
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    chk("c0_req", {31'd0, imem_req}, 32'd1);
    chk("c0_addr", imem_addr, 32'd16);
    step();
    #1;
    chk("c1_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("c1_addr", imem_addr, 32'd20);
    step();
    #1;
    chk("c2_first_pc", fetch_pc, 32'd16);
    step();
    for (int c = 3; c < 6; c++) begin
      #1;
      chk("stream_valid", {31'd0, fetch_valid}, 32'd1);
      chk("stream_addr", imem_addr, 32'd16 + 32'(4 * c));
      step();
    end

    // Back-pressure: buffer fills, issue stops, head holds
    fetch_ready = 1'b0;
    run(1);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_valid", {31'd0, fetch_valid}, 32'd1);
      chk("stall_head", fetch_pc, exp_pc);
      step();
    end
    fetch_ready = 1'b1;
    run(6);

    // Redirect mid-stream
    redirect_valid = 1'b1; redirect_pc = 32'd40;
    #1; chk("redir_no_issue", {31'd0, imem_req}, 32'd0); step();
    redirect_valid = 1'b0;
    #1;
    chk("redir_valid_low", {31'd0, fetch_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'd40);
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    step();

    // Walk off the end of memory into a fault
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (fault) seen = 1'b1;
      else step();
    end
    chk("fault_seen", {31'd0, fault}, 32'd1);
    chk("fault_pc_64", fault_pc, 32'd64);
    chk("drained_thru_60", exp_pc, 32'd64);
    step();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("fault_no_req", {31'd0, imem_req}, 32'd0);
      chk("fault_hold", {31'd0, fault}, 32'd1);
      chk("fault_empty", {31'd0, fetch_valid}, 32'd0);
      step();
    end
    redirect_valid = 1'b1; redirect_pc = 32'd16;
    #1; step();
    redirect_valid = 1'b0;
    #1;
    chk("recover_fault", {31'd0, fault}, 32'd0);
    chk("recover_addr", imem_addr, 32'd16);
    chk("recover_req", {31'd0, imem_req}, 32'd1);
    step();
    run(8);

    // Misaligned redirect faults immediately
    redirect_valid = 1'b1; redirect_pc = 32'd42;
    #1; step();
    redirect_valid = 1'b0;
    #1;
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'd42);
    chk("mis_no_req", {31'd0, imem_req}, 32'd0);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'd16;
    #1; step();
    redirect_valid = 1'b0;
    run(6);

    // Halt pulse: no issue while high, stream continues afterwards
    dlv_before = delivered;
    halt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1; chk("halt_no_req", {31'd0, imem_req}, 32'd0); step();
    end
    halt = 1'b0;
    run(8);
    chk("halt_progress", {31'd0, delivered > dlv_before + 6}, 32'd1);

    // Reset with a response in flight and an entry buffered
    fetch_ready = 1'b0;
    reset = 1'b1;
    #1; step();
    reset = 1'b0; fetch_ready = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("mid_rst_fault", {31'd0, fault}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'd16);
    step();
    #1; chk("mid_rst_valid_c1", {31'd0, fetch_valid}, 32'd0); step();
    #1; chk("mid_rst_first_pc", fetch_pc, 32'd16); step();

    // Randomized traffic scored by the delivery model
    dlv_before = delivered;
    for (int c = 0; c < 400; c++) begin
      fetch_ready    = ($urandom_range(0, 3) != 0);
      halt           = ($urandom_range(0, 5) == 0);
      redirect_valid = ($urandom_range(0, 23) == 0);
      redirect_pc    = 32'd16 + 32'(4 * $urandom_range(0, 11));
      #1;
      if (fault) chk("rnd_fault_pc", fault_pc, 32'd64);
      step();
    end
    chk("rnd_progress", {31'd0, delivered > dlv_before + 50}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
